demux1x4_unstripe: RTL and testbench
====================================

// Module: demux1x4_unstripe
// PURPOSE
//  Receive-side byte un-striper; the inverse of the TX 4-lane-to-1 merge mux.
//  Takes one byte+valid stream and deals valid bytes round-robin onto lanes 0..3.
//  Presents each completed group of four as a parallel word with per-lane valids.
//  Flushes a partial group after an idle gap, and realigns on an external align pulse.
//  Sits between the RX serial-to-parallel stage and the RX lane FIFOs; single clock domain.
// PARAMETERS
//  DATA_W      8   width of each byte/lane
//  IDLE_FLUSH  4   consecutive validin=0 cycles that flush a partial group; 0 = never flush
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  reset      in   1        synchronous, active-high reset
//  in         in   DATA_W   incoming byte
//  validin    in   1        in carries a valid byte this cycle
//  align      in   1        1-cycle pulse: discard partial group, next byte goes to lane 0
//  out0..out3 out  DATA_W   lane data of last emitted group (lane0 = first byte)
//  valid      out  4        per-lane valid of last emitted group, valid[i] <-> outi
//  strobe     out  1        1-cycle pulse: out0..3/valid updated this cycle
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-group): out0..3=0, valid=0, strobe=0.
//    Lane counter, idle counter and holding regs are cleared; the partial group is dropped, not emitted.
//  - Lane counter lc (2b) names the lane for the next valid byte.
//    lc advances only when validin=1 and wraps 3->0. validin=0 never advances lc.
//  - validin=1 with lc<3: byte goes to hold[lc]; outputs are unchanged; strobe=0.
//  - validin=1 with lc=3, on that edge:
//      out0..2 <= hold[0..2]; out3 <= in; valid <= 4'b1111; strobe <= 1; lc <= 0.
//    Latency: group visible 1 cycle after its 4th byte is presented.
//  - Outputs hold their value between strobes. strobe is high for exactly one cycle per emitted group.
//  - Idle counter ic: cleared when validin=1 or lc=0; otherwise increments when validin=0.
//  - Flush: when IDLE_FLUSH>0, lc!=0, validin=0 and ic=IDLE_FLUSH-1 (the IDLE_FLUSH-th idle cycle), on that edge:
//      outi <= hold[i] for i<lc, else 0; valid[i] <= (i<lc); strobe <= 1; lc <= 0; ic <= 0.
//    Partial valid patterns are therefore only 0001, 0011 or 0111.
//  - align=1 has priority over the group logic:
//      partial hold data is discarded (no strobe, outputs unchanged); ic <= 0.
//      If validin=1 in the same cycle, that byte goes to hold[0] and lc <= 1; otherwise lc <= 0.
//  - align=1 while lc=0 with no partial data is harmless (identical to the above).
//  - Back-to-back groups: 8 consecutive valid bytes give strobes 4 cycles apart; no bubble and no byte lost.
//  - No backpressure: the downstream stage must accept every strobe.
//  - Widths: ic is sized to hold IDLE_FLUSH-1. All lane indices are modulo 4.
// TESTING
//  1. reset=1 for 2 cycles with validin toggling -> out0..3=0, valid=0, strobe never asserts.
//  2. Bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles with validin=1
//       -> next cycle out0..3 = 11,22,33,44; valid=1111; strobe=1 for 1 cycle.
//  3. Bytes 0xA0,0xA1 with validin=1, then validin=0 (IDLE_FLUSH=4)
//       -> on the 4th idle cycle: out0=A0, out1=A1, out2=out3=0, valid=0011, single strobe.
//  4. Bytes 0x01,0x02, then align=1 together with validin=1 and in=0x10, then 0x11,0x12,0x13
//       -> one strobe only: out0..3 = 10,11,12,13, valid=1111; 01/02 never appear.
//  5. Stream 0x00..0x07 with validin gaps of 1-2 cycles (each gap < IDLE_FLUSH)
//       -> two strobes: {00,01,02,03} then {04,05,06,07}; valid=1111 both times.
//  6. reset asserted after 3 bytes of a group, then 4 new bytes B0..B3
//       -> no flush strobe; first strobe has out0..3 = B0..B3.

Source files
------------

// File: rtl/demux1x4_unstripe.sv
// demux1x4_unstripe: deal a byte stream round-robin onto 4 lanes, emitting full or flushed partial groups
//   clk, reset       : clock, synchronous active-high reset
//   in, validin      : incoming byte and its valid
//   align            : pulse that drops any partial group and restarts at lane 0
//   out0..out3       : lane data of the last emitted group
//   valid            : per-lane valid of the last emitted group
//   strobe           : one-cycle pulse when out0..3/valid were just updated
module demux1x4_unstripe #(
  parameter int DATA_W     = 8,
  parameter int IDLE_FLUSH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              validin,
  input  logic              align,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [3:0]        valid,
  output logic              strobe
);
  localparam int ICW = IDLE_FLUSH > 1 ? $clog2(IDLE_FLUSH) : 1;
  localparam logic [ICW-1:0] IC_MAX = ICW'(IDLE_FLUSH > 0 ? IDLE_FLUSH - 1 : 0);
  logic [1:0]        lc_q, lc_d;
  logic [ICW-1:0]    ic_q, ic_d;
  logic [DATA_W-1:0] hold_q [3];
  logic [DATA_W-1:0] hold_d [3];
  logic [DATA_W-1:0] out_q [4];
  logic [DATA_W-1:0] out_d [4];
  logic [3:0]        valid_q, valid_d;
  logic              strobe_q, strobe_d;
  always_comb begin
    lc_d     = lc_q;
    ic_d     = ic_q;
    hold_d   = hold_q;
    out_d    = out_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    if (align) begin
      // align wins: partial data is dropped, a same-cycle byte starts the new group
      ic_d = '0;
      lc_d = validin ? 2'd1 : 2'd0;
      if (validin) hold_d[0] = in;
    end else if (validin) begin
      ic_d = '0;
      lc_d = lc_q + 2'd1;
      if (lc_q == 2'd3) begin
        out_d    = '{hold_q[0], hold_q[1], hold_q[2], in};
        valid_d  = 4'b1111;
        strobe_d = 1'b1;
      end else begin
        hold_d[lc_q] = in;
      end
    end else if (lc_q != 2'd0) begin
      if (IDLE_FLUSH > 0 && ic_q == IC_MAX) begin
        // lanes beyond the partial fill are zeroed, not left stale
        for (int i = 0; i < 3; i++) begin
          out_d[i]   = (i < int'(lc_q)) ? hold_q[i] : '0;
          valid_d[i] = i < int'(lc_q);
        end
        out_d[3]   = '0;
        valid_d[3] = 1'b0;
        strobe_d   = 1'b1;
        lc_d       = 2'd0;
        ic_d       = '0;
      end else begin
        ic_d = ic_q + 1'b1;
      end
    end else begin
      ic_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lc_q     <= '0;
      ic_q     <= '0;
      hold_q   <= '{default: '0};
      out_q    <= '{default: '0};
      valid_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      lc_q     <= lc_d;
      ic_q     <= ic_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end
  assign out0   = out_q[0];
  assign out1   = out_q[1];
  assign out2   = out_q[2];
  assign out3   = out_q[3];
  assign valid  = valid_q;
  assign strobe = strobe_q;
endmodule

// File: tb/tb_demux1x4_unstripe.sv
// tb_demux1x4_unstripe: queue-based model check every cycle plus directed literal checks
module tb_demux1x4_unstripe;
  localparam int IDLE_FLUSH = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_b = '0;
  logic       validin = 1'b0;
  logic       align = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid;
  logic       strobe;
  int checks = 0;
  int errors = 0;
  int dut_strobes = 0;
  demux1x4_unstripe #(.DATA_W(8), .IDLE_FLUSH(IDLE_FLUSH)) dut (
    .clk(clk), .reset(reset), .in(in_b), .validin(validin), .align(align),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .valid(valid), .strobe(strobe)
  );
  always #5 clk = ~clk;
  logic [7:0] q[$];
  int         idle = 0;
  logic [7:0] m_out [4] = '{default: '0};
  logic [3:0] m_valid = '0;
  logic       m_strobe = 1'b0;
  task automatic emit(input int n);
    for (int i = 0; i < 4; i++) begin
      m_out[i]   = (i < n) ? q[i] : 8'h00;
      m_valid[i] = i < n;
    end
    m_strobe = 1'b1;
    q.delete();
    idle = 0;
  endtask
  always @(posedge clk) begin
    m_strobe = 1'b0;
    if (reset) begin
      q.delete();
      idle = 0;
      m_out = '{default: '0};
      m_valid = '0;
    end else if (align) begin
      q.delete();
      idle = 0;
      if (validin) q.push_back(in_b);
    end else if (validin) begin
      idle = 0;
      q.push_back(in_b);
      if (q.size() == 4) emit(4);
    end else if (q.size() != 0) begin
      idle++;
      if (IDLE_FLUSH > 0 && idle == IDLE_FLUSH) emit(q.size());
    end else begin
      idle = 0;
    end
  end
  always @(negedge clk) begin
    checks++;
    if ({out0, out1, out2, out3, valid, strobe} !== {m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_strobe}) begin
      errors++;
      $display("FAIL cycle t=%0t got out=%h_%h_%h_%h valid=%b strobe=%b want out=%h_%h_%h_%h valid=%b strobe=%b",
               $time, out0, out1, out2, out3, valid, strobe,
               m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_strobe);
    end
    if (strobe) dut_strobes++;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] d, input logic v, input logic a);
    in_b = d;
    validin = v;
    align = a;
    @(posedge clk);
    #1;
    validin = 1'b0;
    align = 1'b0;
  endtask
  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask
  task automatic bytes(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) step(w[31-8*i -: 8], 1'b1, 1'b0);
  endtask
  int s0;
  initial begin
    @(posedge clk);
    #1;
    step(8'h5A, 1'b1, 1'b0);
    step(8'h5B, 1'b0, 1'b0);
    step(8'h5C, 1'b1, 1'b0);
    chk("t1_reset_out", {out0, out1, out2, out3}, 32'h0);
    chk("t1_reset_vs", {27'd0, valid, strobe}, 32'h0);
    chk("t1_no_strobe", dut_strobes, 0);
    reset = 1'b0;
    bytes(32'h11223344, 4);
    chk("t2_out", {out0, out1, out2, out3}, 32'h11223344);
    chk("t2_vs", {27'd0, valid, strobe}, {27'd0, 4'b1111, 1'b1});
    idles(1);
    chk("t2_strobe_drop", {31'd0, strobe}, 32'd0);
    s0 = dut_strobes;
    bytes(32'hA0A10000, 2);
    idles(3);
    chk("t3_not_yet", {31'd0, strobe}, 32'd0);
    idles(1);
    chk("t3_out", {out0, out1, out2, out3}, 32'hA0A10000);
    chk("t3_vs", {27'd0, valid, strobe}, {27'd0, 4'b0011, 1'b1});
    idles(2);
    chk("t3_one_strobe", dut_strobes - s0, 1);
    s0 = dut_strobes;
    bytes(32'h01020000, 2);
    step(8'h10, 1'b1, 1'b1);
    bytes(32'h11121300, 3);
    chk("t4_out", {out0, out1, out2, out3}, 32'h10111213);
    chk("t4_vs", {27'd0, valid, strobe}, {27'd0, 4'b1111, 1'b1});
    idles(6);
    chk("t4_one_strobe", dut_strobes - s0, 1);
    s0 = dut_strobes;
    step(8'h00, 1'b1, 1'b0); idles(1);
    step(8'h01, 1'b1, 1'b0); step(8'h02, 1'b1, 1'b0); idles(2);
    step(8'h03, 1'b1, 1'b0);
    chk("t5_g1", {out0, out1, out2, out3}, 32'h00010203);
    step(8'h04, 1'b1, 1'b0); idles(2);
    step(8'h05, 1'b1, 1'b0); idles(1);
    step(8'h06, 1'b1, 1'b0); step(8'h07, 1'b1, 1'b0);
    chk("t5_g2", {out0, out1, out2, out3}, 32'h04050607);
    chk("t5_valid", {28'd0, valid}, 32'hF);
    idles(6);
    chk("t5_two_strobes", dut_strobes - s0, 2);
    s0 = dut_strobes;
    bytes(32'hC0C1C200, 3);
    reset = 1'b1;
    step(8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    chk("t6_reset_clears", {out0, out1, out2, out3, 3'd0, valid[0]}, 36'h0);
    bytes(32'hB0B1B2B3, 4);
    chk("t6_out", {out0, out1, out2, out3}, 32'hB0B1B2B3);
    idles(6);
    chk("t6_one_strobe", dut_strobes - s0, 1);
    bytes(32'h21222300, 3);
    step(8'h30, 1'b1, 1'b1);
    bytes(32'h31323300, 3);
    chk("align_lc3_out", {out0, out1, out2, out3}, 32'h30313233);
    idles(2);
    bytes(32'h55000000, 1);
    idles(4);
    chk("flush1_out", {out0, out1, out2, out3}, 32'h55000000);
    chk("flush1_valid", {28'd0, valid}, 32'h1);
    bytes(32'h61626300, 3);
    idles(4);
    chk("flush3_out", {out0, out1, out2, out3}, 32'h61626300);
    chk("flush3_valid", {28'd0, valid}, 32'h7);
    step(8'h00, 1'b0, 1'b1);
    chk("align_idle_hold", {out0, out1, out2, out3}, 32'h61626300);
    s0 = dut_strobes;
    bytes(32'hD0D1D2D3, 4);
    chk("b2b_g1", {out0, out1, out2, out3}, 32'hD0D1D2D3);
    bytes(32'hE0E1E200, 3);
    chk("b2b_gap", {31'd0, strobe}, 32'd0);
    bytes(32'hE3000000, 1);
    chk("b2b_g2", {out0, out1, out2, out3, 3'd0, strobe}, {32'hE0E1E2E3, 4'h1});
    idles(6);
    chk("b2b_two_strobes", dut_strobes - s0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
